mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synthesizable multi-channel memory target for the GPU memory request protocol. It sits on the memory side of the program and data memory channels that the GPU's memory controllers drive.
- Each channel accepts valid/address(/data) requests, waits a fixed latency, then asserts ready with read data or a write acknowledgement. It holds ready until the initiator drops valid.
- Replaces the behavioural memory model in standalone and FPGA builds.

Parameters:
ADDR_BITS, 8, address width; depth = 2**ADDR_BITS words
DATA_BITS, 8, word width (16 for program memory)
CHANNELS, 4, number of independent request channels
LATENCY, 2, cycles from request capture to ready assertion; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
read_valid  in  CHANNELS  per-channel read request
read_address  in  CHANNELS*ADDR_BITS  per-channel read address (packed, channel 0 in LSBs)
read_ready  out  CHANNELS  read data valid / request served
read_data  out  CHANNELS*DATA_BITS  per-channel read data
write_valid  in  CHANNELS  per-channel write request
write_address  in  CHANNELS*ADDR_BITS  per-channel write address
write_data  in  CHANNELS*DATA_BITS  per-channel write data
write_ready  out  CHANNELS  write committed acknowledgement
init_we  in  1  backdoor load strobe; overrides all channel writes in that cycle
init_addr  in  ADDR_BITS  backdoor load address
init_data  in  DATA_BITS  backdoor load data

Behaviour:
- Single clock domain: clk. reset is synchronous and active-high.
- Reset:
  - All channel FSMs go to IDLE.
  - read_ready, write_ready and read_data are 0.
  - Latency counters are 0.
  - Storage contents are NOT cleared.
  - Reset mid-request abandons the request; a pending write is not committed.
- Per-channel FSM with states IDLE, WAIT, RESP:
  - IDLE:
    - If read_valid: capture address, op=READ, counter=LATENCY-1, go to WAIT.
    - Else if write_valid: capture address and data, op=WRITE, counter=LATENCY-1, go to WAIT.
    - If both are asserted, read wins and the write is taken after the read completes.
  - WAIT:
    - Counter decrements by 1 each cycle.
    - When the counter is 0, go to RESP and on that edge:
      - READ: register read_data = mem[addr] and set read_ready=1.
      - WRITE: commit mem[addr]=data and set write_ready=1.
    - With LATENCY=1, ready rises on the 2nd edge after valid is first seen high.
    - Generally, ready is high LATENCY+1 edges after capture... (precisely: capture edge, then LATENCY further edges).
    - If the op's valid drops during WAIT: go to IDLE, no commit, no ready.
  - RESP:
    - Ready and read_data are held stable while valid stays high.
    - When valid is sampled low: ready goes to 0 on that edge and the FSM goes to IDLE. read_data keeps its last value.
    - A new request is accepted no earlier than the cycle after returning to IDLE, so there is at least one ready-low cycle between transactions.
- Addresses and data are captured at request acceptance. Later changes to the address/data inputs during WAIT or RESP are ignored.
- Storage:
  - Single array of 2**ADDR_BITS x DATA_BITS.
  - Writes from all channels and init commit at the clock edge.
  - Reads capture the pre-edge contents, so a read and a write to the same address on the same edge return the OLD value.
- Write conflicts on the same edge and same address:
  - init_we wins over every channel.
  - Otherwise the lowest-numbered channel wins.
  - The losing channels still assert write_ready; their data is discarded.
- init_we is permitted during reset and sets no ready signals.
- Channels are fully independent. No arbitration stalls: every channel sees identical latency regardless of load.
- Address widths are exact; no out-of-range addresses exist.

Test Plan:
1. Channel 0 write addr 0x10 data 0xA5, LATENCY=2, then read addr 0x10 -> write_ready[0] rises 2 edges after capture; read_ready[0] rises 2 edges after capture with read_data[7:0]=0xA5; ready falls the edge after valid drops.
2. All 4 channels read addrs 0..3, preloaded via init with 0x11,0x22,0x33,0x44, on the same cycle -> all four ready on the same edge with the matching data.
3. Channels 1 and 2 write addr 0x20 with 0x01 and 0x02 on the same edge -> both write_ready assert; a subsequent read returns 0x01.
4. Channel 3 read_valid asserted one cycle then dropped during WAIT -> read_ready[3] never asserts; FSM back in IDLE; a next request is served with normal latency.
5. Reset asserted while channel 0 is in WAIT on a write of 0x7F to 0x30 -> all ready signals 0 next edge; mem[0x30] keeps its old value; data loaded earlier via init survives reset.
6. Channel 0 asserts read and write simultaneously to addr 5 (old 0x09, new 0x0C) -> read served first with 0x09; then the write completes; a final read returns 0x0C.

Source files
------------

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Multi-channel memory target for the GPU memory request protocol. Each
// channel accepts a valid/address(/data) request, waits a fixed LATENCY, then
// raises ready with read data (reads) or after committing the word (writes).
// Ready is held until the initiator drops the corresponding valid.
//
// Parameters
//   ADDR_BITS : address width, storage depth is 2**ADDR_BITS words
//   DATA_BITS : word width
//   CHANNELS  : number of independent request channels
//   LATENCY   : cycles from request capture to ready (1..15)
//
// Ports
//   clk            : clock
//   reset          : synchronous active-high reset (storage is not cleared)
//   read_valid     : per-channel read request
//   read_address   : per-channel read address, channel 0 in the LSBs
//   read_ready     : per-channel read served / read_data valid
//   read_data      : per-channel registered read data, channel 0 in the LSBs
//   write_valid    : per-channel write request
//   write_address  : per-channel write address, channel 0 in the LSBs
//   write_data     : per-channel write data, channel 0 in the LSBs
//   write_ready    : per-channel write committed acknowledgement
//   init_we        : backdoor load strobe, beats every channel write
//   init_addr      : backdoor load address
//   init_data      : backdoor load data
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4,
    parameter int LATENCY   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            read_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0]  read_address,
    output logic [CHANNELS-1:0]            read_ready,
    output logic [CHANNELS*DATA_BITS-1:0]  read_data,
    input  logic [CHANNELS-1:0]            write_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0]  write_address,
    input  logic [CHANNELS*DATA_BITS-1:0]  write_data,
    output logic [CHANNELS-1:0]            write_ready,
    input  logic                           init_we,
    input  logic [ADDR_BITS-1:0]           init_addr,
    input  logic [DATA_BITS-1:0]           init_data
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = 4;
    // Counter is loaded at capture and the response fires when it reaches
    // zero, giving LATENCY edges between capture and ready.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_r      [CHANNELS];
    state_t                 state_nxt_s  [CHANNELS];
    logic [ADDR_BITS-1:0]   addr_r       [CHANNELS];
    logic [ADDR_BITS-1:0]   addr_nxt_s   [CHANNELS];
    logic [DATA_BITS-1:0]   wdata_r      [CHANNELS];
    logic [DATA_BITS-1:0]   wdata_nxt_s  [CHANNELS];
    logic [CNT_W-1:0]       count_r      [CHANNELS];
    logic [CNT_W-1:0]       count_nxt_s  [CHANNELS];
    logic [DATA_BITS-1:0]   read_data_r  [CHANNELS];
    logic [DATA_BITS-1:0]   mem_r        [DEPTH];

    logic [CHANNELS-1:0]    op_write_r;
    logic [CHANNELS-1:0]    op_write_nxt_s;
    logic [CHANNELS-1:0]    read_ready_r;
    logic [CHANNELS-1:0]    read_ready_nxt_s;
    logic [CHANNELS-1:0]    write_ready_r;
    logic [CHANNELS-1:0]    write_ready_nxt_s;
    logic [CHANNELS-1:0]    rd_load_s;
    logic [CHANNELS-1:0]    wr_commit_s;
    logic [CHANNELS-1:0]    op_valid_s;

    // Valid line belonging to the operation each channel currently holds.
    always_comb begin
        op_valid_s = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (op_write_r[c]) begin
                op_valid_s[c] = write_valid[c];
            end else begin
                op_valid_s[c] = read_valid[c];
            end
        end
    end

    // Per-channel next-state, capture and response decode.
    always_comb begin
        op_write_nxt_s    = op_write_r;
        read_ready_nxt_s  = read_ready_r;
        write_ready_nxt_s = write_ready_r;
        rd_load_s         = {CHANNELS{1'b0}};
        wr_commit_s       = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            state_nxt_s[c] = state_r[c];
            addr_nxt_s[c]  = addr_r[c];
            wdata_nxt_s[c] = wdata_r[c];
            count_nxt_s[c] = count_r[c];
            case (state_r[c])
                ST_IDLE: begin
                    read_ready_nxt_s[c]  = 1'b0;
                    write_ready_nxt_s[c] = 1'b0;
                    // Read has priority; a concurrent write stays pending on
                    // its valid line and is taken once the read finishes.
                    if (read_valid[c]) begin
                        state_nxt_s[c]    = ST_WAIT;
                        op_write_nxt_s[c] = 1'b0;
                        addr_nxt_s[c]     = read_address[c*ADDR_BITS +: ADDR_BITS];
                        count_nxt_s[c]    = CNT_LOAD;
                    end else if (write_valid[c]) begin
                        state_nxt_s[c]    = ST_WAIT;
                        op_write_nxt_s[c] = 1'b1;
                        addr_nxt_s[c]     = write_address[c*ADDR_BITS +: ADDR_BITS];
                        wdata_nxt_s[c]    = write_data[c*DATA_BITS +: DATA_BITS];
                        count_nxt_s[c]    = CNT_LOAD;
                    end else begin
                        state_nxt_s[c] = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Withdrawn request: abandon without commit or ready.
                    if (!op_valid_s[c]) begin
                        state_nxt_s[c] = ST_IDLE;
                    end else if (count_r[c] == {CNT_W{1'b0}}) begin
                        state_nxt_s[c] = ST_RESP;
                        if (op_write_r[c]) begin
                            wr_commit_s[c]       = 1'b1;
                            write_ready_nxt_s[c] = 1'b1;
                        end else begin
                            rd_load_s[c]         = 1'b1;
                            read_ready_nxt_s[c]  = 1'b1;
                        end
                    end else begin
                        count_nxt_s[c] = count_r[c] - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (!op_valid_s[c]) begin
                        state_nxt_s[c]       = ST_IDLE;
                        read_ready_nxt_s[c]  = 1'b0;
                        write_ready_nxt_s[c] = 1'b0;
                    end else begin
                        state_nxt_s[c] = ST_RESP;
                    end
                end
                default: begin
                    state_nxt_s[c]       = ST_IDLE;
                    read_ready_nxt_s[c]  = 1'b0;
                    write_ready_nxt_s[c] = 1'b0;
                end
            endcase
        end
    end

    // Channel state, captured request and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c]     <= ST_IDLE;
                addr_r[c]      <= {ADDR_BITS{1'b0}};
                wdata_r[c]     <= {DATA_BITS{1'b0}};
                count_r[c]     <= {CNT_W{1'b0}};
                read_data_r[c] <= {DATA_BITS{1'b0}};
            end
            op_write_r    <= {CHANNELS{1'b0}};
            read_ready_r  <= {CHANNELS{1'b0}};
            write_ready_r <= {CHANNELS{1'b0}};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= state_nxt_s[c];
                addr_r[c]  <= addr_nxt_s[c];
                wdata_r[c] <= wdata_nxt_s[c];
                count_r[c] <= count_nxt_s[c];
                // Non-blocking read of the array returns pre-edge contents,
                // so a same-edge write to this address is not visible.
                if (rd_load_s[c]) begin
                    read_data_r[c] <= mem_r[addr_r[c]];
                end else begin
                    read_data_r[c] <= read_data_r[c];
                end
            end
            op_write_r    <= op_write_nxt_s;
            read_ready_r  <= read_ready_nxt_s;
            write_ready_r <= write_ready_nxt_s;
        end
    end

    // Storage: later assignments win, so channels are applied from highest to
    // lowest number and the backdoor load last. Not cleared by reset.
    always_ff @(posedge clk) begin
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (!reset && wr_commit_s[c]) begin
                mem_r[addr_r[c]] <= wdata_r[c];
            end
        end
        if (init_we) begin
            mem_r[init_addr] <= init_data;
        end
    end

    // Output packing.
    always_comb begin
        read_data = {(CHANNELS*DATA_BITS){1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            read_data[c*DATA_BITS +: DATA_BITS] = read_data_r[c];
        end
    end

    assign read_ready  = read_ready_r;
    assign write_ready = write_ready_r;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. A shadow array models storage; each
// scenario task drives requests and compares latency, ready and data against
// values derived from the shadow array and the LATENCY parameter.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int CH  = 4;
    localparam int LAT = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [CH-1:0]       read_valid;
    logic [CH*AB-1:0]    read_address;
    logic [CH-1:0]       read_ready;
    logic [CH*DB-1:0]    read_data;
    logic [CH-1:0]       write_valid;
    logic [CH*AB-1:0]    write_address;
    logic [CH*DB-1:0]    write_data;
    logic [CH-1:0]       write_ready;
    logic                init_we;
    logic [AB-1:0]       init_addr;
    logic [DB-1:0]       init_data;

    logic [DB-1:0]       shadow [256];
    int                  checks   = 0;
    int                  failures = 0;

    mem_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .read_valid(read_valid), .read_address(read_address),
        .read_ready(read_ready), .read_data(read_data),
        .write_valid(write_valid), .write_address(write_address),
        .write_data(write_data), .write_ready(write_ready),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input int ch, input logic [AB-1:0] a, input logic v);
        read_address[ch*AB +: AB] = a;
        read_valid[ch]            = v;
    endtask

    task automatic set_write(input int ch, input logic [AB-1:0] a,
                             input logic [DB-1:0] d, input logic v);
        write_address[ch*AB +: AB] = a;
        write_data[ch*DB +: DB]    = d;
        write_valid[ch]            = v;
    endtask

    task automatic init_load(input logic [AB-1:0] a, input logic [DB-1:0] d);
        init_we = 1'b1; init_addr = a; init_data = d;
        tick();
        init_we = 1'b0;
        shadow[a] = d;
    endtask

    // Edges from the current point until read_ready[ch] is seen; -1 on timeout.
    task automatic wait_rd(input int ch, output int edges);
        edges = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (read_ready[ch]) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int ch, output int edges);
        edges = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (write_ready[ch]) begin
                edges = n;
                break;
            end
        end
    endtask

    // Full read transaction; returns latency and the data seen with ready.
    task automatic do_read(input int ch, input logic [AB-1:0] a,
                           output int edges, output logic [DB-1:0] d);
        set_read(ch, a, 1'b1);
        wait_rd(ch, edges);
        d = read_data[ch*DB +: DB];
        set_read(ch, a, 1'b0);
        tick();
    endtask

    task automatic do_write(input int ch, input logic [AB-1:0] a,
                            input logic [DB-1:0] d, output int edges);
        set_write(ch, a, d, 1'b1);
        wait_wr(ch, edges);
        set_write(ch, a, d, 1'b0);
        tick();
        shadow[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (read_ready !== 4'h0 || write_ready !== 4'h0 || read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: rr=%h wr=%h rd=%h required 0/0/0",
                     read_ready, write_ready, read_data);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (read_ready !== 4'h0 || write_ready !== 4'h0) begin
            failures++;
            $display("FAIL idle_after_reset: rr=%h wr=%h required 0/0", read_ready, write_ready);
        end
    endtask

    task automatic test_write_read();
        int e; logic [DB-1:0] d;
        set_write(0, 8'h10, 8'hA5, 1'b1);
        wait_wr(0, e);
        checks++;
        if (e !== LAT + 1) begin
            failures++; $display("FAIL wr_latency: got %0d required %0d", e, LAT + 1);
        end
        tick();
        checks++;
        if (write_ready[0] !== 1'b1) begin
            failures++; $display("FAIL wr_hold: got %b required 1", write_ready[0]);
        end
        set_write(0, 8'h10, 8'hA5, 1'b0);
        tick();
        shadow[8'h10] = 8'hA5;
        checks++;
        if (write_ready[0] !== 1'b0) begin
            failures++; $display("FAIL wr_drop: got %b required 0", write_ready[0]);
        end
        set_read(0, 8'h10, 1'b1);
        wait_rd(0, e);
        checks++;
        if (e !== LAT + 1 || read_data[7:0] !== 8'hA5) begin
            failures++;
            $display("FAIL rd_basic: lat=%0d data=%h required %0d/a5", e, read_data[7:0], LAT + 1);
        end
        set_read(0, 8'h10, 1'b0);
        tick();
        checks++;
        if (read_ready[0] !== 1'b0 || read_data[7:0] !== 8'hA5) begin
            failures++;
            $display("FAIL rd_drop: rr=%b data=%h required 0/a5", read_ready[0], read_data[7:0]);
        end
    endtask

    // Random write-then-read on random channels; the address/data inputs are
    // scrambled after capture, which must not affect the transaction.
    task automatic test_random();
        int e; int ch; logic [AB-1:0] a; logic [DB-1:0] d, got;
        for (int i = 0; i < 10; i++) begin
            ch = $urandom_range(0, CH - 1);
            a  = AB'($urandom_range(64, 255));
            d  = DB'($urandom);
            set_write(ch, a, d, 1'b1);
            tick();
            set_write(ch, AB'($urandom), DB'($urandom), 1'b1);
            wait_wr(ch, e);
            checks++;
            if (e !== LAT) begin
                failures++; $display("FAIL rand_wr_lat ch%0d: got %0d required %0d", ch, e + 1, LAT + 1);
            end
            set_write(ch, a, d, 1'b0);
            tick();
            shadow[a] = d;
            ch = $urandom_range(0, CH - 1);
            set_read(ch, a, 1'b1);
            tick();
            read_address[ch*AB +: AB] = AB'($urandom);
            wait_rd(ch, e);
            got = read_data[ch*DB +: DB];
            set_read(ch, a, 1'b0);
            tick();
            checks++;
            if (e !== LAT || got !== shadow[a]) begin
                failures++;
                $display("FAIL rand_rd ch%0d addr %h: lat=%0d data=%h required %0d/%h",
                         ch, a, e + 1, got, LAT + 1, shadow[a]);
            end
        end
    endtask

    task automatic test_parallel_read();
        int e; logic [CH*DB-1:0] exp; logic [AB-1:0] a [CH];
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < CH; c++) begin
                if (r == 0) begin
                    a[c] = AB'(c);
                    init_load(a[c], DB'(8'h11 * (c + 1)));
                end else begin
                    a[c] = AB'($urandom_range(64, 255));
                    init_load(a[c], DB'($urandom));
                end
            end
            for (int c = 0; c < CH; c++) begin
                exp[c*DB +: DB] = shadow[a[c]];
                set_read(c, a[c], 1'b1);
            end
            e = -1;
            for (int n = 1; n <= 40; n++) begin
                tick();
                if (read_ready !== 4'h0) begin e = n; break; end
            end
            checks++;
            if (e !== LAT + 1 || read_ready !== 4'hF || read_data !== exp) begin
                failures++;
                $display("FAIL parallel_read r%0d: lat=%0d rr=%h data=%h required %0d/f/%h",
                         r, e, read_ready, read_data, LAT + 1, exp);
            end
            read_valid = 4'h0;
            tick();
        end
    endtask

    task automatic test_write_conflict();
        int e; logic [DB-1:0] d;
        set_write(1, 8'h20, 8'h01, 1'b1);
        set_write(2, 8'h20, 8'h02, 1'b1);
        e = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (write_ready !== 4'h0) begin e = n; break; end
        end
        checks++;
        if (e !== LAT + 1 || write_ready !== 4'b0110) begin
            failures++;
            $display("FAIL conflict_ready: lat=%0d wr=%b required %0d/0110", e, write_ready, LAT + 1);
        end
        write_valid = 4'h0;
        tick();
        shadow[8'h20] = 8'h01;
        do_read(3, 8'h20, e, d);
        checks++;
        if (d !== shadow[8'h20]) begin
            failures++; $display("FAIL conflict_low_ch: got %h required %h", d, shadow[8'h20]);
        end
        // Backdoor load on the commit edge of a channel write, same address.
        set_write(0, 8'h21, 8'h55, 1'b1);
        repeat (LAT) tick();
        init_we = 1'b1; init_addr = 8'h21; init_data = 8'hEE;
        tick();
        init_we = 1'b0;
        checks++;
        if (write_ready[0] !== 1'b1) begin
            failures++; $display("FAIL init_conflict_ready: got %b required 1", write_ready[0]);
        end
        set_write(0, 8'h21, 8'h55, 1'b0);
        tick();
        shadow[8'h21] = 8'hEE;
        do_read(1, 8'h21, e, d);
        checks++;
        if (d !== shadow[8'h21]) begin
            failures++; $display("FAIL init_wins: got %h required %h", d, shadow[8'h21]);
        end
    endtask

    task automatic test_abort();
        int e; logic seen; logic [DB-1:0] d;
        init_load(8'h40, 8'h12);
        init_load(8'h41, 8'h34);
        set_read(3, 8'h41, 1'b1);
        tick();
        set_read(3, 8'h41, 1'b0);
        seen = 1'b0;
        repeat (6) begin tick(); seen = seen | read_ready[3]; end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL rd_abort: ready seen=%b required 0", seen);
        end
        do_read(3, 8'h41, e, d);
        checks++;
        if (e !== LAT + 1 || d !== 8'h34) begin
            failures++; $display("FAIL after_abort: lat=%0d data=%h required %0d/34", e, d, LAT + 1);
        end
        set_write(1, 8'h40, 8'h99, 1'b1);
        tick();
        set_write(1, 8'h40, 8'h99, 1'b0);
        seen = 1'b0;
        repeat (6) begin tick(); seen = seen | write_ready[1]; end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL wr_abort_ready: seen=%b required 0", seen);
        end
        do_read(2, 8'h40, e, d);
        checks++;
        if (d !== shadow[8'h40]) begin
            failures++; $display("FAIL wr_abort_commit: got %h required %h", d, shadow[8'h40]);
        end
    endtask

    task automatic test_reset_mid();
        int e; logic [DB-1:0] d;
        init_load(8'h30, 8'h3C);
        init_load(8'h31, 8'h5A);
        do_read(0, 8'h31, e, d);
        set_write(0, 8'h30, 8'h7F, 1'b1);
        set_read(1, 8'h31, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (read_ready !== 4'h0 || write_ready !== 4'h0 || read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: rr=%h wr=%h rd=%h required 0/0/0", read_ready, write_ready, read_data);
        end
        init_we = 1'b1; init_addr = 8'h32; init_data = 8'h77;
        tick();
        init_we = 1'b0;
        shadow[8'h32] = 8'h77;
        set_write(0, 8'h30, 8'h7F, 1'b0);
        set_read(1, 8'h31, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        do_read(0, 8'h30, e, d);
        checks++;
        if (d !== 8'h3C) begin
            failures++; $display("FAIL reset_no_commit: got %h required 3c", d);
        end
        do_read(2, 8'h31, e, d);
        checks++;
        if (d !== 8'h5A) begin
            failures++; $display("FAIL init_survives_reset: got %h required 5a", d);
        end
        do_read(3, 8'h32, e, d);
        checks++;
        if (d !== 8'h77) begin
            failures++; $display("FAIL init_during_reset: got %h required 77", d);
        end
    endtask

    task automatic test_read_write_same();
        int e; logic [DB-1:0] d;
        init_load(8'h05, 8'h09);
        set_read(0, 8'h05, 1'b1);
        set_write(0, 8'h05, 8'h0C, 1'b1);
        wait_rd(0, e);
        checks++;
        if (e !== LAT + 1 || read_data[7:0] !== 8'h09 || write_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL rw_read_first: lat=%0d data=%h wr=%b required %0d/09/0",
                     e, read_data[7:0], write_ready[0], LAT + 1);
        end
        set_read(0, 8'h05, 1'b0);
        wait_wr(0, e);
        checks++;
        if (e !== LAT + 2) begin
            failures++; $display("FAIL rw_write_after: lat=%0d required %0d", e, LAT + 2);
        end
        set_write(0, 8'h05, 8'h0C, 1'b0);
        tick();
        shadow[8'h05] = 8'h0C;
        do_read(0, 8'h05, e, d);
        checks++;
        if (d !== 8'h0C) begin
            failures++; $display("FAIL rw_final_read: got %h required 0c", d);
        end
    endtask

    initial begin
        reset = 1'b1;
        read_valid = '0; read_address = '0;
        write_valid = '0; write_address = '0; write_data = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        test_reset();
        test_write_read();
        test_parallel_read();
        test_write_conflict();
        test_abort();
        test_reset_mid();
        test_read_write_same();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
